// File: rtl/flash_arb_pkg.sv
// Shared state encoding, default widths and flash command codes for the flash arbiter.
// The arbiter's optional host-priority mode is selected by FLASH_ARB_HOST_PRIORITY_EN.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int FL_ADDR_W = 20;
  localparam int FL_DATA_W = 8;
  localparam int FL_CMD_W  = 3;

  // Command encodings understood by the flash controller.
  localparam logic [FL_CMD_W-1:0] CMD_READ       = 3'd0;
  localparam logic [FL_CMD_W-1:0] CMD_WRITE      = 3'd1;
  localparam logic [FL_CMD_W-1:0] CMD_SEC_ERASE  = 3'd2;
  localparam logic [FL_CMD_W-1:0] CMD_CHIP_ERASE = 3'd3;
  localparam logic [FL_CMD_W-1:0] CMD_READ_ID    = 3'd4;

endpackage

// File: rtl/flash_rr_pick.sv
// Combinational circular priority picker: first set request at or after the pointer wins.
module flash_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Circular scan starting at the pointer position.
  always_comb begin
    logic [IDX_W-1:0] w_k;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      w_k = IDX_W'((int'(i_ptr) + i) % N);
      if (!o_valid && i_req[w_k]) begin
        o_valid    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/flash_rr_arbiter.sv
// Round-robin arbiter sharing one flash controller among NUM_PORTS requesters.
// Define FLASH_ARB_HOST_PRIORITY_EN to make port 0 win every arbitration it joins.
module flash_rr_arbiter
  import flash_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = FL_ADDR_W,
  parameter int DATA_W    = FL_DATA_W,
  parameter int CMD_W     = FL_CMD_W,
  parameter int GAP_CYC   = 2
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [NUM_PORTS-1:0]        iREQ,
  input  logic [NUM_PORTS*ADDR_W-1:0] iADDR,
  input  logic [NUM_PORTS*CMD_W-1:0]  iCMD,
  input  logic [NUM_PORTS*DATA_W-1:0] iDATA,
  output logic [NUM_PORTS*DATA_W-1:0] oDATA,
  output logic [NUM_PORTS-1:0]        oACK,
  output logic [NUM_PORTS-1:0]        oGNT,
  output logic                        oBUSY,
  output logic [ADDR_W-1:0]           oFL_ADDR,
  output logic [DATA_W-1:0]           oFL_DATA,
  output logic [CMD_W-1:0]            oFL_CMD,
  output logic                        oFL_Start,
  input  logic                        iFL_Ready,
  input  logic [DATA_W-1:0]           iFL_DATA
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int GAP_W = 4;

  arb_state_t r_state, w_state_nxt;

  logic [PTR_W-1:0]            r_ptr, r_win, w_ptr_nxt;
  logic [GAP_W-1:0]            r_gap;
  logic [NUM_PORTS-1:0]        r_gnt, r_ack;
  logic [NUM_PORTS*DATA_W-1:0] r_odata;
  logic [ADDR_W-1:0]           r_fl_addr;
  logic [DATA_W-1:0]           r_fl_data;
  logic [CMD_W-1:0]            r_fl_cmd;
  logic                        r_start;

  logic [NUM_PORTS-1:0] w_pick_req, w_pick_gnt, w_sel_gnt;
  logic [PTR_W-1:0]     w_pick_idx, w_sel_idx;
  logic                 w_pick_valid, w_sel_valid;
  logic                 w_gap_done, w_load, w_done, w_gap_step, w_release;

  flash_rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (PTR_W)
  ) u_pick (
    .i_req   (w_pick_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

`ifdef FLASH_ARB_HOST_PRIORITY_EN
  // Host is pulled out of the rotation and overrides it whenever it asks.
  assign w_pick_req = {iREQ[NUM_PORTS-1:1], 1'b0};

  // Winner selection: host first, otherwise the rotating picker.
  always_comb begin
    if (iREQ[0]) begin
      w_sel_gnt   = {{(NUM_PORTS-1){1'b0}}, 1'b1};
      w_sel_idx   = '0;
      w_sel_valid = 1'b1;
    end else begin
      w_sel_gnt   = w_pick_gnt;
      w_sel_idx   = w_pick_idx;
      w_sel_valid = w_pick_valid;
    end
  end

  // Pointer advance; host grants leave the rotation untouched.
  always_comb begin
    if (r_win == '0) begin
      w_ptr_nxt = r_ptr;
    end else if (r_win == PTR_W'(NUM_PORTS - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_win + PTR_W'(1);
    end
  end
`else
  assign w_pick_req = iREQ;

  // Winner selection straight from the rotating picker.
  always_comb begin
    w_sel_gnt   = w_pick_gnt;
    w_sel_idx   = w_pick_idx;
    w_sel_valid = w_pick_valid;
  end

  // Pointer advance to the port after the winner, wrapping at NUM_PORTS.
  always_comb begin
    if (r_win == PTR_W'(NUM_PORTS - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = r_win + PTR_W'(1);
    end
  end
`endif

  assign w_gap_done = (r_gap == GAP_W'(GAP_CYC - 1));

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; Ready must be seen low before a high counts as completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_sel_valid) w_state_nxt = START; else w_state_nxt = IDLE;
      START:   if (!iFL_Ready)  w_state_nxt = BUSY;  else w_state_nxt = START;
      BUSY:    if (iFL_Ready)   w_state_nxt = GAP;   else w_state_nxt = BUSY;
      GAP:     if (w_gap_done)  w_state_nxt = IDLE;  else w_state_nxt = GAP;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output strobes decoded from the current state.
  always_comb begin
    w_load     = 1'b0;
    w_done     = 1'b0;
    w_gap_step = 1'b0;
    w_release  = 1'b0;
    case (r_state)
      IDLE:    if (w_sel_valid) w_load = 1'b1; else w_load = 1'b0;
      START:   w_load = 1'b0;
      BUSY:    if (iFL_Ready) w_done = 1'b1; else w_done = 1'b0;
      GAP:     if (w_gap_done) w_release = 1'b1; else w_gap_step = 1'b1;
      default: w_load = 1'b0;
    endcase
  end

  // Registered outputs: latch the winner, return read data, pace the gap.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_ptr     <= '0;
      r_win     <= '0;
      r_gap     <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_odata   <= '0;
      r_fl_addr <= '0;
      r_fl_data <= '0;
      r_fl_cmd  <= '0;
      r_start   <= 1'b0;
    end else begin
      r_ack <= '0;
      if (w_load) begin
        r_gnt     <= w_sel_gnt;
        r_win     <= w_sel_idx;
        r_fl_addr <= iADDR[w_sel_idx*ADDR_W +: ADDR_W];
        r_fl_cmd  <= iCMD[w_sel_idx*CMD_W +: CMD_W];
        r_fl_data <= iDATA[w_sel_idx*DATA_W +: DATA_W];
        r_start   <= 1'b1;
      end
      if (w_done) begin
        r_start                          <= 1'b0;
        r_ack                            <= r_gnt;
        r_odata[r_win*DATA_W +: DATA_W]  <= iFL_DATA;
        r_ptr                            <= w_ptr_nxt;
        r_gap                            <= '0;
      end
      if (w_gap_step) begin
        r_gap <= r_gap + GAP_W'(1);
      end
      if (w_release) begin
        r_gnt <= '0;
        r_gap <= '0;
      end
    end
  end

  assign oDATA     = r_odata;
  assign oACK      = r_ack;
  assign oGNT      = r_gnt;
  assign oBUSY     = (r_state != IDLE);
  assign oFL_ADDR  = r_fl_addr;
  assign oFL_DATA  = r_fl_data;
  assign oFL_CMD   = r_fl_cmd;
  assign oFL_Start = r_start;

endmodule

// File: tb/tb_flash_rr_arbiter.sv
// Directed plus randomized bench for flash_rr_arbiter with a transaction-level reference model.
module tb_flash_rr_arbiter;

  localparam int NP  = 4;
  localparam int AW  = 20;
  localparam int DW  = 8;
  localparam int CW  = 3;
  localparam int GAP = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    r_req = '0;
  logic [NP*AW-1:0] r_addr = '0;
  logic [NP*CW-1:0] r_cmd = '0;
  logic [NP*DW-1:0] r_wdata = '0;
  logic             fl_ready = 1'b1;
  logic [DW-1:0]    fl_rdata = '0;

  logic [NP*DW-1:0] oDATA;
  logic [NP-1:0]    oACK, oGNT;
  logic             oBUSY, oFL_Start;
  logic [AW-1:0]    oFL_ADDR;
  logic [DW-1:0]    oFL_DATA;
  logic [CW-1:0]    oFL_CMD;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: rotation pointer and the last read byte returned to each port.
  int            m_ptr = 0;
  logic [DW-1:0] m_data [NP];

  flash_rr_arbiter #(
    .NUM_PORTS (NP), .ADDR_W (AW), .DATA_W (DW), .CMD_W (CW), .GAP_CYC (GAP)
  ) dut (
    .iCLK (clk), .iRST (rst), .iREQ (r_req), .iADDR (r_addr), .iCMD (r_cmd),
    .iDATA (r_wdata), .oDATA (oDATA), .oACK (oACK), .oGNT (oGNT), .oBUSY (oBUSY),
    .oFL_ADDR (oFL_ADDR), .oFL_DATA (oFL_DATA), .oFL_CMD (oFL_CMD),
    .oFL_Start (oFL_Start), .iFL_Ready (fl_ready), .iFL_DATA (fl_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP*DW-1:0] exp_odata();
    logic [NP*DW-1:0] v;
    for (int k = 0; k < NP; k++) v[k*DW +: DW] = m_data[k];
    return v;
  endfunction

  // Winner = first requesting port at or after the pointer, going round the ring.
  function automatic int model_pick();
`ifdef FLASH_ARB_HOST_PRIORITY_EN
    if (r_req[0]) return 0;
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_ptr + k) % NP;
      if (p != 0 && r_req[p]) return p;
    end
`else
    for (int k = 0; k < NP; k++) begin
      int p;
      p = (m_ptr + k) % NP;
      if (r_req[p]) return p;
    end
`endif
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   64'(oGNT),      64'd0);
    chk({tag, "_ack"},   64'(oACK),      64'd0);
    chk({tag, "_busy"},  64'(oBUSY),     64'd0);
    chk({tag, "_start"}, 64'(oFL_Start), 64'd0);
    chk({tag, "_addr"},  64'(oFL_ADDR),  64'd0);
    chk({tag, "_wdat"},  64'(oFL_DATA),  64'd0);
    chk({tag, "_cmd"},   64'(oFL_CMD),   64'd0);
    chk({tag, "_odata"}, 64'(oDATA),     64'd0);
  endtask

  // One full transaction, entered at a negedge while the arbiter is idle.
  task automatic run_txn(input int stale, input int busyc, input logic [DW-1:0] rd,
                         input bit drop, output int win);
    logic [NP-1:0] oh;
    win = model_pick();
    oh  = NP'(1) << win;
    @(posedge clk); @(negedge clk);
    chk("grant",    64'(oGNT),      64'(oh));
    chk("fl_addr",  64'(oFL_ADDR),  64'(r_addr[win*AW +: AW]));
    chk("fl_cmd",   64'(oFL_CMD),   64'(r_cmd[win*CW +: CW]));
    chk("fl_wdata", 64'(oFL_DATA),  64'(r_wdata[win*DW +: DW]));
    chk("start_on", 64'(oFL_Start), 64'd1);
    chk("busy_on",  64'(oBUSY),     64'd1);
    repeat (stale) begin
      @(posedge clk); @(negedge clk);
      chk("stale_no_ack", 64'(oACK),      64'd0);
      chk("stale_start",  64'(oFL_Start), 64'd1);
    end
    fl_ready = 1'b0;
    if (drop) r_req[win] = 1'b0;
    repeat (busyc) begin
      @(posedge clk); @(negedge clk);
      chk("busy_no_ack", 64'(oACK),      64'd0);
      chk("busy_start",  64'(oFL_Start), 64'd1);
    end
    fl_ready = 1'b1;
    fl_rdata = rd;
    @(posedge clk); @(negedge clk);
    m_data[win] = rd;
`ifdef FLASH_ARB_HOST_PRIORITY_EN
    if (win != 0) m_ptr = (win + 1) % NP;
`else
    m_ptr = (win + 1) % NP;
`endif
    chk("ack",       64'(oACK),      64'(oh));
    chk("odata",     64'(oDATA),     64'(exp_odata()));
    chk("start_off", 64'(oFL_Start), 64'd0);
    chk("gap_gnt",   64'(oGNT),      64'(oh));
    for (int g = 1; g < GAP; g++) begin
      @(posedge clk); @(negedge clk);
      chk("gap_no_ack", 64'(oACK),      64'd0);
      chk("gap_hold",   64'(oGNT),      64'(oh));
      chk("gap_start",  64'(oFL_Start), 64'd0);
    end
    @(posedge clk); @(negedge clk);
    chk("idle_gnt",   64'(oGNT),      64'd0);
    chk("idle_busy",  64'(oBUSY),     64'd0);
    chk("idle_start", 64'(oFL_Start), 64'd0);
  endtask

  initial begin
    int win;
    for (int k = 0; k < NP; k++) m_data[k] = '0;
    for (int k = 0; k < NP; k++) begin
      r_addr[k*AW +: AW]  = AW'(32'h1000 * (k + 1) + k);
      r_cmd[k*CW +: CW]   = CW'(k + 1);
      r_wdata[k*DW +: DW] = DW'(8'h10 + k);
    end

    // Reset state.
    @(posedge clk); @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("idle_nogrant", 64'(oGNT),  64'd0);
      chk("idle_notbusy", 64'(oBUSY), 64'd0);
    end

    // All four requesting continuously: two full rotations.
    r_req = 4'b1111;
    for (int i = 0; i < 2 * NP; i++) run_txn(0, 2, DW'($urandom), 1'b0, win);
    r_req = '0;

    // Single request on port 1.
    r_addr[1*AW +: AW] = 20'h12345;
    r_req = 4'b0010;
    run_txn(0, 5, 8'hA5, 1'b0, win);
    r_req = '0;

    // Stale Ready held high for two cycles after Start.
    r_req = 4'b0001;
    run_txn(2, 3, 8'h3C, 1'b0, win);
    r_req = '0;

    // Request on port 2 dropped during BUSY.
    r_req = 4'b0100;
    run_txn(0, 3, 8'h5A, 1'b1, win);
    r_req = '0;

    // Reset mid-BUSY, then a fresh arbitration from pointer 0.
    r_req = 4'b0100;
    @(posedge clk); @(negedge clk);
    chk("rst_pre_grant", 64'(oGNT), 64'b0100);
    fl_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rst_pre_noack", 64'(oACK), 64'd0);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk); @(negedge clk);
    chk_all_zero("rst_held");
    rst = 1'b0;
    fl_ready = 1'b1;
    m_ptr = 0;
    for (int k = 0; k < NP; k++) m_data[k] = '0;
    r_req = 4'b1010;
    run_txn(0, 2, 8'hC3, 1'b0, win);
    r_req[win] = 1'b0;
    run_txn(0, 2, 8'h77, 1'b0, win);
    r_req = '0;

    // Randomized traffic under the requester hold rule.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NP; k++) begin
        if (!r_req[k] && $urandom_range(0, 2) == 0) begin
          r_req[k]            = 1'b1;
          r_addr[k*AW +: AW]  = AW'($urandom);
          r_cmd[k*CW +: CW]   = CW'($urandom);
          r_wdata[k*DW +: DW] = DW'($urandom);
        end
      end
      if (r_req == '0) r_req[$urandom_range(0, NP - 1)] = 1'b1;
      run_txn($urandom_range(0, 2), $urandom_range(1, 6), DW'($urandom),
              ($urandom_range(0, 7) == 0), win);
      if ($urandom_range(0, 3) != 0) r_req[win] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_rr_arbiter.md
Name: flash_rr_arbiter

Overview:
Dynamic round-robin arbiter sharing the single flash controller among NUM_PORTS requesters (host USB API plus async readers). Replaces static select-line steering with a per-port req/ack handshake. Latches the winner's address, command and data, sequences the controller's Start/Ready handshake, and returns read data to the winning port only. Sits between the requesters and the flash controller.

Parameters:
NUM_PORTS, 4, number of requesters; legal range 2..8.
ADDR_W, 20, flash address width.
DATA_W, 8, flash data width.
CMD_W, 3, flash command width.
GAP_CYC, 2, idle recovery cycles after each completion before the next grant; legal range 1..15.

Ports:
iCLK  in  1  system clock.
iRST  in  1  asynchronous active-high reset.
iREQ  in  NUM_PORTS  per-port request level.
iADDR  in  NUM_PORTS*ADDR_W  per-port address; port k occupies slice k.
iCMD  in  NUM_PORTS*CMD_W  per-port command.
iDATA  in  NUM_PORTS*DATA_W  per-port write data.
oDATA  out  NUM_PORTS*DATA_W  per-port read data; each slice is held until that port's next completion.
oACK  out  NUM_PORTS  one-cycle completion pulse, one-hot.
oGNT  out  NUM_PORTS  one-hot current owner; all zero when idle.
oBUSY  out  1  high in every state except IDLE.
oFL_ADDR  out  ADDR_W  address to the controller.
oFL_DATA  out  DATA_W  write data to the controller.
oFL_CMD  out  CMD_W  command to the controller.
oFL_Start  out  1  controller start.
iFL_Ready  in  1  controller ready; low means busy.
iFL_DATA  in  DATA_W  controller read data.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer 0; gap counter 0. Reset asserted mid-operation aborts immediately. No ack is issued and oDATA is cleared.
- IDLE: if any iREQ is set, grant the first set bit, searching circularly from the pointer. Register that port's ADDR/CMD/DATA onto the oFL_* outputs, set oGNT, and go to START. Arbitration takes 1 cycle.
- START: oFL_Start=1. On iFL_Ready==0 (controller accepted), go to BUSY.
- BUSY: oFL_Start stays 1. On iFL_Ready==1:
  - capture iFL_DATA into the winner's oDATA slice;
  - drop oFL_Start;
  - pulse oACK[winner] for 1 cycle;
  - set pointer = (winner+1) mod NUM_PORTS;
  - go to GAP.
- GAP: hold for GAP_CYC cycles with oGNT still set, then clear oGNT and go to IDLE. This guarantees a stale Ready-high is never taken as a new completion.
- Latency: minimum from request to ack is 3 cycles plus controller busy time. Request to next grant spacing is at least GAP_CYC+1 cycles.
- Requester rule: hold iREQ and its ADDR/CMD/DATA until oACK. The values are latched at grant, so later changes do not matter. If iREQ drops after grant, the operation still completes and is acked. A port that keeps iREQ high after its ack is re-arbitrated normally.
- Simultaneous requests: the pointer order decides the winner. With all ports requesting, each port is served once per NUM_PORTS grants.
- When no port is granted, oFL_ADDR/oFL_DATA/oFL_CMD hold their last values and oFL_Start is 0.
- Pointer wraps from NUM_PORTS-1 to 0.

Optional Feature:
FLASH_ARB_HOST_PRIORITY_EN
- Defined: port 0 (host) wins any arbitration in which iREQ[0] is set. The remaining ports rotate round-robin among themselves, and the pointer is not advanced by port 0 grants.
- Undefined: pure round-robin across all ports as described in Behaviour.

Decomposition:
- Shared package flash_arb_pkg holds:
  - the state enum: IDLE, START, BUSY, GAP;
  - default widths ADDR_W/DATA_W/CMD_W;
  - the flash CMD_W encodings already used by the controller.
- Sub-module flash_rr_pick: combinational circular priority picker. Inputs are the request vector and the pointer; outputs are the one-hot grant and the grant index. It is reusable for other shared resources.
- The FSM, latches and data return stay in the top module.

Test Plan:
- Single request: iREQ=4'b0010, iADDR[1]=20'h12345; controller model returns 8'hA5 after 5 busy cycles.
  Required: oFL_ADDR=20'h12345, oFL_Start high until Ready rises, oACK=4'b0010 for 1 cycle, oDATA[1]=8'hA5, other oDATA slices unchanged.
- All four requesting continuously.
  Required: grant order 0,1,2,3,0,… with each ack one-hot; with GAP_CYC=2, at least 3 cycles between an ack and the next oFL_Start rise.
- Stale Ready: controller Ready held high for 2 cycles after Start.
  Required: no ack until Ready has gone low and then high again.
- Request dropped after grant: iREQ[2] deasserted in BUSY.
  Required: operation completes, oACK[2] pulses, oDATA[2] is updated.
- Reset mid-BUSY: assert iRST during BUSY.
  Required: next cycle all outputs are 0 and no oACK. After release, a pending iREQ[3] gets a fresh grant starting from pointer 0.
- With FLASH_ARB_HOST_PRIORITY_EN defined and iREQ=4'b1111 held.
  Required: port 0 wins every arbitration, with no grants to ports 1–3.
